// File: rtl/score_display_pkg.sv
// Shared definitions for the score BCD display block.
// Contents:
//   state_t       - conversion FSM encoding (IDLE / CONV / COMMIT)
//   BCD_DIGITS    - number of decimal digits per score (3)
//   BIN_W         - width of the clamped binary score (10)
//   SHREG_W       - double-dabble shift register width (BCD digits + binary)
//   GLYPH_*       - 7-segment glyphs, active-high, bit0 = seg a .. bit6 = seg g
//   bcd_adjust()  - double-dabble "add 3 if >= 5" nibble correction
package score_display_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int BCD_DIGITS = 3;
   localparam int BIN_W      = 10;
   localparam int SHREG_W    = 4 * BCD_DIGITS + BIN_W;

   // Shift index of the final (10th) double-dabble step.
   localparam logic [3:0] LAST_SHIFT = 4'd9;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   // A BCD digit that is 5 or more overflows on the next shift; adding 3
   // first makes the shifted value carry correctly into the next digit.
   function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

endpackage

// File: rtl/score_bcd_display_seg7_decoder.sv
// seg7_decoder: one BCD digit to one 7-segment pattern.
// Ports:
//   bcd    in  4  BCD digit 0-9 (10-15 decode to blank)
//   blank  in  1  force the digit dark (leading-zero suppression)
//   seg    out 7  segment pattern, bit0 = seg a .. bit6 = seg g
// Parameter SEG_ACTIVE_LOW: 1 drives lit segments as 0 (board HEX displays).
module seg7_decoder
   import score_display_pkg::*;
#(
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   logic [6:0] glyph_s;

   // Digit lookup in active-high form, then the board polarity is applied.
   always_comb begin
      glyph_s = GLYPH_BLANK;
      if (blank) begin
         glyph_s = GLYPH_BLANK;
      end else begin
         case (bcd)
            4'd0:    glyph_s = GLYPH_0;
            4'd1:    glyph_s = GLYPH_1;
            4'd2:    glyph_s = GLYPH_2;
            4'd3:    glyph_s = GLYPH_3;
            4'd4:    glyph_s = GLYPH_4;
            4'd5:    glyph_s = GLYPH_5;
            4'd6:    glyph_s = GLYPH_6;
            4'd7:    glyph_s = GLYPH_7;
            4'd8:    glyph_s = GLYPH_8;
            4'd9:    glyph_s = GLYPH_9;
            default: glyph_s = GLYPH_BLANK;
         endcase
      end
      if (SEG_ACTIVE_LOW != 0) begin
         seg = ~glyph_s;
      end else begin
         seg = glyph_s;
      end
   end

endmodule

// File: rtl/score_bcd_display.sv
// score_bcd_display: binary score to 3-digit BCD score / high score plus six
// 7-segment patterns. Conversion is a double-dabble FSM doing one shift per clk.
// Ports:
//   clk          in   1        system clock
//   rst          in   1        synchronous active-high reset
//   score_count  in   SCORE_W  binary score from the pipe scroller
//   score_BCD    out  12       {hundreds,tens,ones} of the current score
//   hiscore_BCD  out  12       {hundreds,tens,ones} of the high score
//   busy         out  1        conversion in flight
//   seven_seg    out  42       {hi_h,hi_t,hi_o,sc_h,sc_t,sc_o}, 7 bits each
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros on the
// displays (ones digit always drawn); BCD outputs are never affected.
module score_bcd_display
   import score_display_pkg::*;
#(
   parameter int SCORE_W        = 32,
   parameter int CLAMP_MAX      = 999,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] score_count,
   output logic [11:0]        score_BCD,
   output logic [11:0]        hiscore_BCD,
   output logic               busy,
   output logic [41:0]        seven_seg
);

   localparam logic [SCORE_W-1:0] CLAMP_FULL = SCORE_W'(CLAMP_MAX);
   localparam logic [BIN_W-1:0]   CLAMP_BIN  = BIN_W'(CLAMP_MAX);
   localparam logic [6:0] SEG_ZERO = (SEG_ACTIVE_LOW != 0) ? ~GLYPH_0 : GLYPH_0;

   state_t             state_r, state_nxt_s;
   logic [SHREG_W-1:0] shreg_r, shreg_nxt_s, adj_s;
   logic [3:0]         cnt_r, cnt_nxt_s;
   logic [BIN_W-1:0]   last_score_r, last_score_nxt_s;
   logic [BIN_W-1:0]   hiscore_bin_r, hiscore_bin_nxt_s;
   logic [BIN_W-1:0]   val_s;
   logic [11:0]        score_nxt_s, hiscore_nxt_s;
   logic               busy_nxt_s;
   logic [23:0]        digits_s;
   logic [5:0]         blank_s;
   logic [41:0]        seg_s;

   // Saturate on the full input width so large scores cannot alias.
   assign val_s = (score_count > CLAMP_FULL) ? CLAMP_BIN : score_count[BIN_W-1:0];

   // Add-3 correction on each BCD nibble before the shift.
   assign adj_s = {bcd_adjust(shreg_r[21:18]), bcd_adjust(shreg_r[17:14]),
                   bcd_adjust(shreg_r[13:10]), shreg_r[BIN_W-1:0]};

   // Next-state and datapath update for the conversion FSM.
   always_comb begin
      state_nxt_s       = state_r;
      shreg_nxt_s       = shreg_r;
      cnt_nxt_s         = cnt_r;
      last_score_nxt_s  = last_score_r;
      hiscore_bin_nxt_s = hiscore_bin_r;
      score_nxt_s       = score_BCD;
      hiscore_nxt_s     = hiscore_BCD;
      busy_nxt_s        = busy;
      case (state_r)
         IDLE: begin
            // Re-comparing against the last converted value means any change
            // made during a conversion is picked up here afterwards.
            if (val_s != last_score_r) begin
               last_score_nxt_s = val_s;
               shreg_nxt_s      = {12'b0, val_s};
               cnt_nxt_s        = 4'd0;
               busy_nxt_s       = 1'b1;
               state_nxt_s      = CONV;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CONV: begin
            shreg_nxt_s = adj_s << 1;
            cnt_nxt_s   = cnt_r + 4'd1;
            if (cnt_r == LAST_SHIFT) begin
               state_nxt_s = COMMIT;
            end else begin
               state_nxt_s = CONV;
            end
         end
         COMMIT: begin
            score_nxt_s = shreg_r[21:10];
            // Strictly greater: an equal score leaves the high score alone.
            if (last_score_r > hiscore_bin_r) begin
               hiscore_bin_nxt_s = last_score_r;
               hiscore_nxt_s     = shreg_r[21:10];
            end else begin
               hiscore_bin_nxt_s = hiscore_bin_r;
               hiscore_nxt_s     = hiscore_BCD;
            end
            busy_nxt_s  = 1'b0;
            state_nxt_s = IDLE;
         end
         default: begin
            busy_nxt_s  = 1'b0;
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Conversion datapath and BCD result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_r       <= '0;
         cnt_r         <= 4'd0;
         last_score_r  <= '0;
         hiscore_bin_r <= '0;
         score_BCD     <= 12'd0;
         hiscore_BCD   <= 12'd0;
         busy          <= 1'b0;
      end else begin
         shreg_r       <= shreg_nxt_s;
         cnt_r         <= cnt_nxt_s;
         last_score_r  <= last_score_nxt_s;
         hiscore_bin_r <= hiscore_bin_nxt_s;
         score_BCD     <= score_nxt_s;
         hiscore_BCD   <= hiscore_nxt_s;
         busy          <= busy_nxt_s;
      end
   end

   assign digits_s = {hiscore_BCD, score_BCD};

`ifdef LEADING_ZERO_BLANK_EN
   // Hundreds blank when zero; tens blank only if hundreds is blank too.
   assign blank_s[5] = (hiscore_BCD[11:8] == 4'd0);
   assign blank_s[4] = blank_s[5] && (hiscore_BCD[7:4] == 4'd0);
   assign blank_s[3] = 1'b0;
   assign blank_s[2] = (score_BCD[11:8] == 4'd0);
   assign blank_s[1] = blank_s[2] && (score_BCD[7:4] == 4'd0);
   assign blank_s[0] = 1'b0;
`else
   assign blank_s = 6'b000000;
`endif

   for (genvar g = 0; g < 6; g++) begin : g_dec
      seg7_decoder #(
         .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
      ) u_dec (
         .bcd   (digits_s[4*g +: 4]),
         .blank (blank_s[g]),
         .seg   (seg_s[7*g +: 7])
      );
   end

   // Registered display patterns, refreshed every clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         seven_seg <= {6{SEG_ZERO}};
      end else begin
         seven_seg <= seg_s;
      end
   end

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed testbench for score_bcd_display (default parameters, active-low segments).
module tb_score_bcd_display;

   logic        clk;
   logic        rst;
   logic [31:0] score_count;
   logic [11:0] score_BCD;
   logic [11:0] hiscore_BCD;
   logic        busy;
   logic [41:0] seven_seg;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc;

   // Active-low glyphs for the digits used below.
   localparam logic [6:0] S0 = 7'h40;
   localparam logic [6:0] S1 = 7'h79;
   localparam logic [6:0] S2 = 7'h24;
   localparam logic [6:0] S3 = 7'h30;
   localparam logic [6:0] S4 = 7'h19;
   localparam logic [6:0] S5 = 7'h12;
   localparam logic [6:0] S7 = 7'h78;
   localparam logic [6:0] S9 = 7'h10;
   localparam logic [6:0] SB = 7'h7F;

   score_bcd_display dut (
      .clk         (clk),
      .rst         (rst),
      .score_count (score_count),
      .score_BCD   (score_BCD),
      .hiscore_BCD (hiscore_BCD),
      .busy        (busy),
      .seven_seg   (seven_seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait for busy to drop, bounded; returns the number of clocks waited.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      rst = 1'b1;
      score_count = 32'd0;
      tick(); tick(); tick();
      chk("rst_score",   42'(score_BCD),   42'h000);
      chk("rst_hiscore", 42'(hiscore_BCD), 42'h000);
      chk("rst_busy",    42'(busy),        42'h0);
      chk("rst_seg",     seven_seg, {S0, S0, S0, S0, S0, S0});
      rst = 1'b0;
      tick(); tick(); tick();
      chk("const_busy",  42'(busy),        42'h0);

      // 0 -> 123
      score_count = 32'd123;
      tick();
      chk("t2_busy_set", 42'(busy), 42'h1);
      wait_done(cyc);
      chk("t2_latency",  42'(cyc),         42'd11);
      chk("t2_score",    42'(score_BCD),   42'h123);
      chk("t2_hiscore",  42'(hiscore_BCD), 42'h123);
      chk("t2_hex0_old", 42'(seven_seg[6:0]), 42'(S0));
      tick();
      chk("t2_seg",      seven_seg, {S1, S2, S3, S1, S2, S3});

      // 123 -> 0 -> 45: high score holds
      score_count = 32'd0;
      tick();
      wait_done(cyc);
      chk("t3_zero",     42'(score_BCD),   42'h000);
      chk("t3_hi_zero",  42'(hiscore_BCD), 42'h123);
      score_count = 32'd45;
      tick();
      wait_done(cyc);
      tick();
      chk("t3_score",    42'(score_BCD),   42'h045);
      chk("t3_hiscore",  42'(hiscore_BCD), 42'h123);
`ifdef LEADING_ZERO_BLANK_EN
      chk("t3_seg",      seven_seg, {S1, S2, S3, SB, S4, S5});
`else
      chk("t3_seg",      seven_seg, {S1, S2, S3, S0, S4, S5});
`endif

      // clamp
      score_count = 32'd5000;
      tick();
      wait_done(cyc);
      tick();
      chk("t4_score",    42'(score_BCD),   42'h999);
      chk("t4_hiscore",  42'(hiscore_BCD), 42'h999);
      chk("t4_seg",      seven_seg, {S9, S9, S9, S9, S9, S9});

      // 10 then 11 during conversion
      score_count = 32'd10;
      tick();
      score_count = 32'd11;
      wait_done(cyc);
      chk("t5_first",    42'(score_BCD), 42'h010);
      tick();
      chk("t5_rebusy",   42'(busy),      42'h1);
      wait_done(cyc);
      chk("t5_latency",  42'(cyc),         42'd11);
      chk("t5_score",    42'(score_BCD),   42'h011);
      chk("t5_hiscore",  42'(hiscore_BCD), 42'h999);

      // reset mid-conversion of 77
      score_count = 32'd77;
      tick(); tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("t6_rst_score", 42'(score_BCD),   42'h000);
      chk("t6_rst_hi",    42'(hiscore_BCD), 42'h000);
      chk("t6_rst_busy",  42'(busy),        42'h0);
      chk("t6_rst_seg",   seven_seg, {S0, S0, S0, S0, S0, S0});
      rst = 1'b0;
      tick();
      chk("t6_restart",   42'(busy), 42'h1);
      wait_done(cyc);
      tick();
      chk("t6_score",     42'(score_BCD),   42'h077);
      chk("t6_hiscore",   42'(hiscore_BCD), 42'h077);
      chk("t6_seg",       seven_seg, {S0, S7, S7, S0, S7, S7});

      // lower score after reset: high score keeps 77
      score_count = 32'd50;
      tick();
      wait_done(cyc);
      chk("t7_score",     42'(score_BCD),   42'h050);
      chk("t7_hiscore",   42'(hiscore_BCD), 42'h077);
      tick(); tick();
      chk("t7_idle_busy", 42'(busy), 42'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
